// File: rtl/ras_pkg.sv
// rtl/ras_pkg.sv - shared types, link-register constants and helpers for the shadow return stack
package ras_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } ras_state_t;

  localparam logic [4:0] RAS_LINK0 = 5'd1;
  localparam logic [4:0] RAS_LINK1 = 5'd5;

  // x1 (ra) and x5 (t0) are the ABI link registers
  function automatic logic is_link(input logic [4:0] r);
    return (r == RAS_LINK0) || (r == RAS_LINK1);
  endfunction

endpackage

// File: rtl/ras_lifo.sv
// rtl/ras_lifo.sv - circular register-array LIFO with saturating count and top replace
module ras_lifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 32,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_replace,
  input  logic [AW-1:0] i_data,
  output logic [AW-1:0] o_top,
  output logic [CW-1:0] o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  // r_ptr is the next free slot; the top entry sits one below it (mod DEPTH)
  logic [AW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_ptr;
  logic [CW-1:0] r_count;
  logic [PW-1:0] w_top_idx;

  assign w_top_idx = r_ptr - PTR_ONE;

  // Storage is deliberately not reset; count gates what is visible
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_ptr] <= i_data;
    end else if (i_replace) begin
      r_mem[w_top_idx] <= i_data;
    end
  end

  // Pointer and count: a push on a full stack wraps over the oldest entry and count saturates
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (i_push) begin
      r_ptr <= r_ptr + PTR_ONE;
      if (r_count != CNT_FULL) begin
        r_count <= r_count + CNT_ONE;
      end
    end else if (i_pop && (r_count != '0)) begin
      r_ptr   <= r_ptr - PTR_ONE;
      r_count <= r_count - CNT_ONE;
    end
  end

  assign o_top   = (r_count == '0) ? '0 : r_mem[w_top_idx];
  assign o_count = r_count;

endmodule

// File: rtl/ras_shadow_stack.sv
// rtl/ras_shadow_stack.sv - shadow return-address stack checking jal/jalr call/return pairing
module ras_shadow_stack
  import ras_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 32
) (
  input  logic                       clk,
  input  logic                       Rst,
  input  logic                       enable,
  input  logic                       id_fire,
  input  logic                       IF_ID_jal,
  input  logic                       IF_ID_jalr,
  input  logic [4:0]                 IF_ID_rd,
  input  logic [4:0]                 IF_ID_rs1,
  input  logic [AW-1:0]              IF_ID_pres_addr,
  input  logic [AW-1:0]              branoff,
  input  logic                       clr,
  output logic                       RAS_rdy,
  output logic                       ras_mismatch,
  output logic                       ras_underflow,
  output logic                       ras_irq,
  output logic [$clog2(DEPTH+1)-1:0] ras_count,
  output logic [AW-1:0]              ras_top
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LINK_OFS = AW'(4);

  ras_state_t    r_state;
  logic          r_rdy;
  logic          r_mismatch;
  logic          r_underflow;
  logic          r_irq;
  logic [AW-1:0] r_cmp_saved;
  logic [AW-1:0] r_cmp_target;

  logic          w_rd_link;
  logic          w_rs1_link;
  logic          w_evt;
  logic          w_push;
  logic          w_pop;
  logic          w_nonempty;
  logic          w_lifo_push;
  logic          w_lifo_pop;
  logic          w_lifo_replace;
  logic [AW-1:0] w_link_addr;
  logic [AW-1:0] w_top;
  logic [CW-1:0] w_count;

  // Events are only honoured while idle; in CHECK the core is stalled so none should arrive
  assign w_rd_link   = is_link(IF_ID_rd);
  assign w_rs1_link  = is_link(IF_ID_rs1);
  assign w_evt       = id_fire & enable & (r_state == IDLE);
  assign w_push      = w_evt & (IF_ID_jal | IF_ID_jalr) & w_rd_link;
  assign w_pop       = w_evt & IF_ID_jalr & w_rs1_link & ~(w_rd_link & (IF_ID_rd == IF_ID_rs1));
  assign w_nonempty  = (w_count != '0);
  assign w_link_addr = IF_ID_pres_addr + LINK_OFS;

  // A coroutine swap (pop then push) on a non-empty stack becomes an in-place top replace
  assign w_lifo_replace = w_pop & w_push & w_nonempty;
  assign w_lifo_pop     = w_pop & ~w_push & w_nonempty;
  assign w_lifo_push    = w_push & ~(w_pop & w_nonempty);

  ras_lifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .CW    (CW)
  ) u_lifo (
    .i_clk     (clk),
    .i_rst_n   (Rst),
    .i_push    (w_lifo_push),
    .i_pop     (w_lifo_pop),
    .i_replace (w_lifo_replace),
    .i_data    (w_link_addr),
    .o_top     (w_top),
    .o_count   (w_count)
  );

  // Return-check FSM with registered ready, interrupt pulse and sticky flags; clr wins over a same-cycle set
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      r_state      <= IDLE;
      r_rdy        <= 1'b1;
      r_mismatch   <= 1'b0;
      r_underflow  <= 1'b0;
      r_irq        <= 1'b0;
      r_cmp_saved  <= '0;
      r_cmp_target <= '0;
    end else begin
      r_irq <= 1'b0;
      case (r_state)
        IDLE: begin
          r_rdy <= 1'b1;
          if (w_pop) begin
            if (w_nonempty) begin
              r_cmp_saved  <= w_top;
              r_cmp_target <= branoff;
              r_state      <= CHECK;
              r_rdy        <= 1'b0;
            end else begin
              r_underflow <= 1'b1;
            end
          end
        end
        CHECK: begin
          r_state <= IDLE;
          r_rdy   <= 1'b1;
          if (r_cmp_saved != r_cmp_target) begin
            r_mismatch <= 1'b1;
            r_irq      <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_rdy   <= 1'b1;
        end
      endcase
      if (clr) begin
        r_mismatch  <= 1'b0;
        r_underflow <= 1'b0;
      end
    end
  end

  assign RAS_rdy       = r_rdy;
  assign ras_mismatch  = r_mismatch;
  assign ras_underflow = r_underflow;
  assign ras_irq       = r_irq;
  assign ras_count     = w_count;
  assign ras_top       = w_top;

endmodule

// File: tb/tb_ras_shadow_stack.sv
// tb/tb_ras_shadow_stack.sv - randomized and directed bench for ras_shadow_stack against a queue model
module tb_ras_shadow_stack;

  localparam int DEPTH = 16;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          Rst;
  logic          enable;
  logic          id_fire;
  logic          IF_ID_jal;
  logic          IF_ID_jalr;
  logic [4:0]    IF_ID_rd;
  logic [4:0]    IF_ID_rs1;
  logic [AW-1:0] IF_ID_pres_addr;
  logic [AW-1:0] branoff;
  logic          clr;
  logic          RAS_rdy;
  logic          ras_mismatch;
  logic          ras_underflow;
  logic          ras_irq;
  logic [4:0]    ras_count;
  logic [AW-1:0] ras_top;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] mq[$];
  logic          m_mm;
  logic          m_uf;

  always #5 clk = ~clk;

  ras_shadow_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk             (clk),
    .Rst             (Rst),
    .enable          (enable),
    .id_fire         (id_fire),
    .IF_ID_jal       (IF_ID_jal),
    .IF_ID_jalr      (IF_ID_jalr),
    .IF_ID_rd        (IF_ID_rd),
    .IF_ID_rs1       (IF_ID_rs1),
    .IF_ID_pres_addr (IF_ID_pres_addr),
    .branoff         (branoff),
    .clr             (clr),
    .RAS_rdy         (RAS_rdy),
    .ras_mismatch    (ras_mismatch),
    .ras_underflow   (ras_underflow),
    .ras_irq         (ras_irq),
    .ras_count       (ras_count),
    .ras_top         (ras_top)
  );

  function automatic logic [AW-1:0] m_top();
    return (mq.size() == 0) ? '0 : mq[$];
  endfunction

  // Reference: a bounded list of return addresses, newest last; oldest falls off when full
  function automatic void model_event(input bit jal, input bit jalr, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [AW-1:0] pc,
                                      input logic [AW-1:0] bo, input bit en,
                                      output bit chk, output bit mis);
    bit rl, sl, push, pop;
    logic [AW-1:0] v;
    logic [AW-1:0] la;
    rl   = (rd == 5'd1) || (rd == 5'd5);
    sl   = (rs1 == 5'd1) || (rs1 == 5'd5);
    push = en && (jal || jalr) && rl;
    pop  = en && jalr && sl && !(rl && rd == rs1);
    chk  = 1'b0;
    mis  = 1'b0;
    if (pop) begin
      if (mq.size() == 0) begin
        m_uf = 1'b1;
      end else begin
        v   = mq.pop_back();
        chk = 1'b1;
        mis = (v != bo);
      end
    end
    if (push) begin
      la = pc + 32'd4;
      if (mq.size() == DEPTH) void'(mq.pop_front());
      mq.push_back(la);
    end
  endfunction

  task automatic fire(input bit jal, input bit jalr, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [AW-1:0] pc, input logic [AW-1:0] bo,
                      output bit chk, output bit mis);
    @(negedge clk);
    IF_ID_jal = jal; IF_ID_jalr = jalr; IF_ID_rd = rd; IF_ID_rs1 = rs1;
    IF_ID_pres_addr = pc; branoff = bo; id_fire = 1'b1;
    model_event(jal, jalr, rd, rs1, pc, bo, enable, chk, mis);
    @(posedge clk); #1;
    id_fire = 1'b0; IF_ID_jal = 1'b0; IF_ID_jalr = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b0; enable = 1'b1; id_fire = 1'b0; IF_ID_jal = 1'b0; IF_ID_jalr = 1'b0;
    IF_ID_rd = '0; IF_ID_rs1 = '0; IF_ID_pres_addr = '0; branoff = '0; clr = 1'b0;
    mq.delete(); m_mm = 1'b0; m_uf = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (RAS_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got %0b exp 1", RAS_rdy); end
    checks++; if (ras_mismatch !== 1'b0) begin errors++; $display("FAIL reset_mm got %0b exp 0", ras_mismatch); end
    checks++; if (ras_underflow !== 1'b0) begin errors++; $display("FAIL reset_uf got %0b exp 0", ras_underflow); end
    checks++; if (ras_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %0b exp 0", ras_irq); end
    checks++; if (ras_count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", ras_count); end
    checks++; if (ras_top !== '0) begin errors++; $display("FAIL reset_top got %0h exp 0", ras_top); end
    Rst = 1'b1;
  endtask

  task automatic test_call_return();
    bit chk, mis;
    fire(1, 0, 5'd1, 5'd0, 32'h100, 32'h0, chk, mis);
    checks++; if (ras_count !== 5'd1) begin errors++; $display("FAIL call_count got %0d exp 1", ras_count); end
    checks++; if (ras_top !== 32'h104) begin errors++; $display("FAIL call_top got %0h exp 104", ras_top); end
    fire(0, 1, 5'd0, 5'd1, 32'h500, 32'h104, chk, mis);
    checks++; if (ras_count !== 5'd0) begin errors++; $display("FAIL ret_count got %0d exp 0", ras_count); end
    checks++; if (RAS_rdy !== 1'b0) begin errors++; $display("FAIL ret_rdy_t1 got %0b exp 0", RAS_rdy); end
    @(posedge clk); #1;
    checks++; if (RAS_rdy !== 1'b1) begin errors++; $display("FAIL ret_rdy_t2 got %0b exp 1", RAS_rdy); end
    checks++; if (ras_irq !== 1'b0) begin errors++; $display("FAIL ret_irq got %0b exp 0", ras_irq); end
    checks++; if (ras_mismatch !== 1'b0) begin errors++; $display("FAIL ret_mm got %0b exp 0", ras_mismatch); end
  endtask

  task automatic test_mismatch();
    bit chk, mis;
    fire(1, 0, 5'd1, 5'd0, 32'h100, 32'h0, chk, mis);
    fire(0, 1, 5'd0, 5'd1, 32'h500, 32'h200, chk, mis);
    checks++; if (ras_irq !== 1'b0 || ras_mismatch !== 1'b0) begin errors++; $display("FAIL mm_t1 got irq=%0b mm=%0b exp 0 0", ras_irq, ras_mismatch); end
    @(posedge clk); #1;
    checks++; if (ras_irq !== 1'b1) begin errors++; $display("FAIL mm_irq_t2 got %0b exp 1", ras_irq); end
    checks++; if (ras_mismatch !== 1'b1) begin errors++; $display("FAIL mm_flag_t2 got %0b exp 1", ras_mismatch); end
    @(posedge clk); #1;
    checks++; if (ras_irq !== 1'b0) begin errors++; $display("FAIL mm_irq_t3 got %0b exp 0", ras_irq); end
    @(negedge clk); clr = 1'b1; @(posedge clk); #1; clr = 1'b0;
    checks++; if (ras_mismatch !== 1'b0) begin errors++; $display("FAIL mm_clr got %0b exp 0", ras_mismatch); end
    // clr during the compare cycle suppresses the flag but the pulse still fires
    fire(1, 0, 5'd1, 5'd0, 32'h100, 32'h0, chk, mis);
    fire(0, 1, 5'd0, 5'd1, 32'h500, 32'h300, chk, mis);
    clr = 1'b1;
    @(posedge clk); #1; clr = 1'b0;
    checks++; if (ras_mismatch !== 1'b0) begin errors++; $display("FAIL clr_prio_mm got %0b exp 0", ras_mismatch); end
    checks++; if (ras_irq !== 1'b1) begin errors++; $display("FAIL clr_prio_irq got %0b exp 1", ras_irq); end
    m_mm = 1'b0;
  endtask

  task automatic test_overflow();
    bit chk, mis;
    logic [AW-1:0] exp_bo;
    for (int i = 0; i < 17; i++) fire(1, 0, 5'd1, 5'd0, 32'(i * 4), 32'h0, chk, mis);
    checks++; if (ras_count !== 5'd16) begin errors++; $display("FAIL ovf_count got %0d exp 16", ras_count); end
    checks++; if (ras_top !== 32'h44) begin errors++; $display("FAIL ovf_top got %0h exp 44", ras_top); end
    for (int i = 0; i < 16; i++) begin
      exp_bo = 32'h44 - 32'(i * 4);
      fire(0, 1, 5'd0, 5'd5, 32'h800, exp_bo, chk, mis);
      checks++; if (RAS_rdy !== 1'b0) begin errors++; $display("FAIL ovf_pop%0d_rdy got %0b exp 0", i, RAS_rdy); end
      @(posedge clk); #1;
      checks++; if (ras_irq !== 1'b0) begin errors++; $display("FAIL ovf_pop%0d_irq got %0b exp 0", i, ras_irq); end
    end
    checks++; if (ras_count !== 5'd0) begin errors++; $display("FAIL ovf_drain got %0d exp 0", ras_count); end
    fire(0, 1, 5'd0, 5'd1, 32'h800, 32'h4, chk, mis);
    checks++; if (ras_underflow !== 1'b1) begin errors++; $display("FAIL uf_flag got %0b exp 1", ras_underflow); end
    checks++; if (RAS_rdy !== 1'b1) begin errors++; $display("FAIL uf_rdy got %0b exp 1", RAS_rdy); end
    @(negedge clk); clr = 1'b1; @(posedge clk); #1; clr = 1'b0;
    m_uf = 1'b0;
    checks++; if (ras_underflow !== 1'b0) begin errors++; $display("FAIL uf_clr got %0b exp 0", ras_underflow); end
  endtask

  task automatic test_coroutine();
    bit chk, mis;
    fire(1, 0, 5'd1, 5'd0, 32'h100, 32'h0, chk, mis);
    fire(0, 1, 5'd1, 5'd5, 32'h300, 32'h104, chk, mis);
    checks++; if (ras_count !== 5'd1) begin errors++; $display("FAIL co_count got %0d exp 1", ras_count); end
    checks++; if (ras_top !== 32'h304) begin errors++; $display("FAIL co_top got %0h exp 304", ras_top); end
    checks++; if (RAS_rdy !== 1'b0) begin errors++; $display("FAIL co_rdy got %0b exp 0", RAS_rdy); end
    @(posedge clk); #1;
    checks++; if (ras_irq !== 1'b0 || ras_mismatch !== 1'b0) begin errors++; $display("FAIL co_mm got irq=%0b mm=%0b exp 0 0", ras_irq, ras_mismatch); end
    // rd==rs1 both links: push only, no compare
    fire(0, 1, 5'd1, 5'd1, 32'h400, 32'hdead, chk, mis);
    checks++; if (ras_count !== 5'd2 || RAS_rdy !== 1'b1) begin errors++; $display("FAIL same_link got count=%0d rdy=%0b exp 2 1", ras_count, RAS_rdy); end
  endtask

  task automatic test_reset_in_check();
    bit chk, mis;
    fire(0, 1, 5'd0, 5'd1, 32'h900, 32'h999, chk, mis);
    Rst = 1'b0; #1;
    mq.delete(); m_mm = 1'b0; m_uf = 1'b0;
    checks++; if (RAS_rdy !== 1'b1) begin errors++; $display("FAIL rstchk_rdy got %0b exp 1", RAS_rdy); end
    checks++; if (ras_count !== 5'd0) begin errors++; $display("FAIL rstchk_count got %0d exp 0", ras_count); end
    checks++; if (ras_top !== '0) begin errors++; $display("FAIL rstchk_top got %0h exp 0", ras_top); end
    @(negedge clk); Rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++; if (ras_irq !== 1'b0 || ras_mismatch !== 1'b0) begin errors++; $display("FAIL rstchk_irq%0d got irq=%0b mm=%0b exp 0 0", i, ras_irq, ras_mismatch); end
    end
  endtask

  task automatic test_enable();
    bit chk, mis;
    fire(1, 0, 5'd1, 5'd0, 32'h100, 32'h0, chk, mis);
    enable = 1'b0;
    fire(1, 0, 5'd5, 5'd0, 32'h200, 32'h0, chk, mis);
    fire(0, 1, 5'd0, 5'd1, 32'h200, 32'h777, chk, mis);
    checks++; if (RAS_rdy !== 1'b1) begin errors++; $display("FAIL en_rdy got %0b exp 1", RAS_rdy); end
    checks++; if (ras_count !== 5'd1 || ras_top !== 32'h104) begin errors++; $display("FAIL en_state got count=%0d top=%0h exp 1 104", ras_count, ras_top); end
    @(posedge clk); #1;
    checks++; if (ras_irq !== 1'b0 || ras_mismatch !== 1'b0 || ras_underflow !== 1'b0) begin errors++; $display("FAIL en_flags got %0b%0b%0b exp 000", ras_irq, ras_mismatch, ras_underflow); end
    enable = 1'b1;
  endtask

  task automatic test_random();
    bit chk, mis, jal, jalr;
    logic [4:0] regs[4];
    logic [4:0] rd, rs1;
    logic [AW-1:0] pc, bo;
    int op;
    regs[0] = 5'd0; regs[1] = 5'd1; regs[2] = 5'd5; regs[3] = 5'd2;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        @(negedge clk); clr = 1'b1; @(posedge clk); #1; clr = 1'b0;
        m_mm = 1'b0; m_uf = 1'b0;
      end
      enable = ($urandom_range(0, 7) != 0);
      op   = $urandom_range(0, 2);
      jal  = (op == 0);
      jalr = (op == 1);
      rd   = regs[$urandom_range(0, 3)];
      rs1  = regs[$urandom_range(0, 3)];
      pc   = {$urandom(), 2'b00} & 32'h0000_fffc;
      bo   = ($urandom_range(0, 2) != 0) ? m_top() : ($urandom() & 32'h0000_fffc);
      fire(jal, jalr, rd, rs1, pc, bo, chk, mis);
      checks++; if (ras_count !== 5'(mq.size())) begin errors++; $display("FAIL rnd%0d_count got %0d exp %0d", n, ras_count, mq.size()); end
      checks++; if (ras_top !== m_top()) begin errors++; $display("FAIL rnd%0d_top got %0h exp %0h", n, ras_top, m_top()); end
      checks++; if (RAS_rdy !== !chk) begin errors++; $display("FAIL rnd%0d_rdy got %0b exp %0b", n, RAS_rdy, !chk); end
      if (chk) begin
        @(posedge clk); #1;
        if (mis) m_mm = 1'b1;
        checks++; if (ras_irq !== mis) begin errors++; $display("FAIL rnd%0d_irq got %0b exp %0b", n, ras_irq, mis); end
      end
      checks++; if (ras_mismatch !== m_mm || ras_underflow !== m_uf) begin errors++; $display("FAIL rnd%0d_flags got mm=%0b uf=%0b exp %0b %0b", n, ras_mismatch, ras_underflow, m_mm, m_uf); end
    end
  endtask

  initial begin
    test_reset();
    test_call_return();
    test_mismatch();
    test_overflow();
    test_coroutine();
    test_reset_in_check();
    test_enable();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
